mpsk_modulator: RTL and testbench
=================================

# mpsk_modulator

Coherent M-PSK transmit modulator: the transmit-side counterpart of the MPSK coherent demodulator. It accepts one Gray-coded symbol per valid/ready transfer and holds it for SPS output samples. Each sample is a carrier I/Q pair: the phase-accumulator NCO phase plus the symbol phase offset, looked up in a sine/cosine table. It drives the DAC / loopback path that feeds the demodulator under test.

## Interface
- M_BITS, 2, bits per symbol (1 = BPSK, 2 = QPSK, 3 = 8PSK); legal range 1..3
- SPS, 8, samples per symbol; legal range 2..256
- PHASE_W, 16, phase accumulator and frequency-word width
- LUT_AW, 8, LUT address width (top LUT_AW bits of phase); LUT_AW <= PHASE_W
- DATA_WIDTH, 16, signed I/Q sample width
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  global clock enable; low = all state holds
- fcw  in  PHASE_W  carrier frequency control word, sampled every enabled RUN cycle
- s_valid  in  1  symbol valid
- s_ready  out  1  symbol ready
- s_bits  in  M_BITS  Gray-coded symbol
- m_valid  out  1  new sample this cycle
- m_last  out  1  last sample of a symbol, qualified by m_valid
- m_i  out  DATA_WIDTH  signed in-phase sample (cos)
- m_q  out  DATA_WIDTH  signed quadrature sample (sin)
- underrun  out  1  one-cycle pulse: symbol ended with no next symbol available

## Operation
- Reset values: state IDLE, accumulator 0, symbol 0, sample counter 0, pipeline valid 0. Outputs: m_i = m_q = 0, m_valid = m_last = underrun = 0, s_ready = 0 while rstn low.
- FSM states are IDLE and RUN.
  - IDLE: s_ready = 1 when en = 1. Accumulator is held at 0.
  - IDLE -> RUN on s_valid && s_ready. The symbol is loaded and the counter is set to 0.
  - RUN: one sample is produced per enabled cycle. Counter counts 0..SPS-1. s_ready = en && (cnt == SPS-1).
  - At cnt == SPS-1 with s_valid: load the new symbol, reset the counter to 0, stay in RUN (back-to-back, no gap).
  - At cnt == SPS-1 without s_valid: go to IDLE and pulse underrun.
- Symbol mapping:
  - k = gray_to_bin(s_bits)
  - sym_phase = k << (PHASE_W - M_BITS)
  - QPSK: 00→0, 01→π/2, 11→π, 10→3π/2
- Phase arithmetic:
  - Each RUN cycle computes phase = acc + sym_phase, mod 2^PHASE_W, then acc <= acc + fcw, mod 2^PHASE_W.
  - Wrap is silent.
  - The accumulator is continuous across back-to-back symbols (phase coherent) and restarts at 0 only on IDLE -> RUN.
- LUT: full-wave table with 2^LUT_AW entries, amplitude 2^(DATA_WIDTH-1)-1, rounded to nearest. Address is phase[PHASE_W-1 -: LUT_AW].
- en low:
  - Every register holds, including the pipeline.
  - m_valid and underrun read 0; s_ready is 0.
  - On en high, output resumes with the held sample, with no loss or duplication.
- Reset mid-symbol: all state returns to reset values immediately; the partial symbol is discarded.
- m_i and m_q hold their last value when m_valid = 0, except after reset (0).

## Timing
- Handshake is sampled at rising edge t0.
- Stage 1 (phase register) updates at t0+1.
- Stage 2 (LUT output register, m_valid, m_last) updates at t0+2.
- Latency from symbol accept to first sample: 2 enabled cycles.
- Per symbol: exactly SPS consecutive m_valid cycles (en held high); m_last on the SPS-th.
- Back-to-back symbols give a continuous m_valid stream; underrun produces a gap.
- underrun is asserted in the same cycle as the final stage-1 sample of the starved symbol.
- fcw changes take effect on the next enabled RUN cycle.

## Structure
- mpsk_pkg holds:
  - the state encoding (IDLE, RUN)
  - the gray_to_bin function
  - the LUT amplitude constant
  - the legal-parameter range checks
- Sub-module mpsk_sincos_lut:
  - address in, registered signed cos/sin out, with enable
  - 1-cycle latency
  - table generated at elaboration
- Top level holds the FSM, the sample counter, the symbol register, the accumulator and the stage-1 phase register.

## Test plan
- BPSK (M_BITS=1), fcw=0, SPS=4, bits 0 then 1 back-to-back -> 4 samples at I=32767, Q=0, then 4 at I=-32767, Q=0. m_last on samples 4 and 8; underrun after the 8th.
- QPSK, fcw=0, symbols 00, 01, 11, 10 -> (I,Q) = (32767,0), (0,32767), (-32767,0), (0,-32767), each held SPS samples, with no m_valid gap.
- QPSK, fcw=0x0400, SPS=8, two symbols 00 -> LUT address advances by 4 per sample (0, 4, ..., 60) with no reset at the symbol boundary.
- Handshake timing and latency:
  - s_valid low at the last sample -> underrun pulse, IDLE, m_valid gap.
  - The next symbol arriving 3 cycles later -> first sample 2 cycles after accept, accumulator restarted at 0.
- en toggled low for 5 cycles mid-symbol -> no m_valid during the gap; the sample sequence afterwards is identical to an uninterrupted run.
- rstn asserted at sample 3 of a symbol:
  - all outputs 0 immediately, s_ready 0;
  - after release, IDLE with s_ready=1;
  - the new symbol produces a fresh, correct sample sequence.

Source files
------------

// File: rtl/mpsk_pkg.sv
// Shared state encoding and elaboration-time helpers for the M-PSK transmit modulator.
package mpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam real PI = 3.14159265358979323846;

  // Symbols are at most 3 bits wide; narrower symbols are zero-extended by the caller.
  function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic int lut_amp(input int data_width);
    return (1 << (data_width - 1)) - 1;
  endfunction

  // Round-half-away-from-zero sample of one full-wave table entry.
  function automatic int lut_entry(input int amp, input int idx, input int aw, input bit want_sin);
    real ang;
    real v;
    ang = 2.0 * PI * real'(idx) / real'(1 << aw);
    v   = real'(amp) * (want_sin ? $sin(ang) : $cos(ang));
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  function automatic bit params_ok(input int m_bits, input int sps, input int phase_w,
                                   input int lut_aw, input int data_width);
    return (m_bits >= 1) && (m_bits <= 3) && (sps >= 2) && (sps <= 256) &&
           (lut_aw >= 1) && (lut_aw <= phase_w) && (phase_w > m_bits) &&
           (data_width >= 2) && (data_width <= 31);
  endfunction

endpackage

// File: rtl/mpsk_sincos_lut.sv
// Full-wave sine/cosine table with a registered, enabled output; table contents are
// constants computed at elaboration.
module mpsk_sincos_lut
  import mpsk_pkg::*;
#(
  parameter int LUT_AW     = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [LUT_AW-1:0]            addr,
  output logic signed [DATA_WIDTH-1:0] cos_val,
  output logic signed [DATA_WIDTH-1:0] sin_val
);

  localparam int DEPTH = 1 << LUT_AW;
  localparam int AMP   = lut_amp(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] cos_tbl [DEPTH];
  logic signed [DATA_WIDTH-1:0] sin_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    assign cos_tbl[i] = DATA_WIDTH'(lut_entry(AMP, i, LUT_AW, 1'b0));
    assign sin_tbl[i] = DATA_WIDTH'(lut_entry(AMP, i, LUT_AW, 1'b1));
  end

  // NOTE: only the output register takes reset; the table is constant logic, so
  // resetting it would mean nothing and would block ROM mapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cos_val <= '0;
      sin_val <= '0;
    end else if (en) begin
      cos_val <= cos_tbl[addr];
      sin_val <= sin_tbl[addr];
    end
  end

endmodule

// File: rtl/mpsk_modulator.sv
// Coherent M-PSK transmit modulator: one Gray-coded symbol per handshake, held for SPS
// carrier samples (NCO phase + symbol phase -> sin/cos table).
module mpsk_modulator
  import mpsk_pkg::*;
#(
  parameter int M_BITS     = 2,
  parameter int SPS        = 8,
  parameter int PHASE_W    = 16,
  parameter int LUT_AW     = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [PHASE_W-1:0]           fcw,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [M_BITS-1:0]            s_bits,
  output logic                         m_valid,
  output logic                         m_last,
  output logic signed [DATA_WIDTH-1:0] m_i,
  output logic signed [DATA_WIDTH-1:0] m_q,
  output logic                         underrun
);

  localparam int               CNT_W      = $clog2(SPS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SPS - 1);
  localparam int               SYM_SHIFT  = PHASE_W - M_BITS;
  localparam int               ADDR_SHIFT = PHASE_W - LUT_AW;

  if (!params_ok(M_BITS, SPS, PHASE_W, LUT_AW, DATA_WIDTH)) begin : g_param_check
    $error("mpsk_modulator: parameter set out of range");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] sym_phase;
  logic [PHASE_W-1:0] phase;
  logic               ph_valid;
  logic               ph_last;
  logic               m_valid_r;
  logic               m_last_r;
  logic               underrun_r;
  logic [2:0]         sym_bin;
  logic [PHASE_W-1:0] sym_phase_next;
  logic               last_sample;

  assign sym_bin        = gray_to_bin(3'(s_bits));
  assign sym_phase_next = PHASE_W'(sym_bin) << SYM_SHIFT;
  assign last_sample    = (cnt == CNT_LAST);

  // Ready is forced low while reset is held, even though the state reads IDLE.
  assign s_ready  = rstn && en && ((state == IDLE) || last_sample);
  assign m_valid  = m_valid_r && en;
  assign m_last   = m_last_r && m_valid;
  assign underrun = underrun_r && en;

  // NOTE: every state register uses non-blocking assignment so each update sees the
  // pre-edge values of the others, matching the flop-to-flop hardware.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      sym_phase  <= '0;
      phase      <= '0;
      ph_valid   <= 1'b0;
      ph_last    <= 1'b0;
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
      underrun_r <= 1'b0;
    end else if (en) begin
      m_valid_r  <= ph_valid;
      m_last_r   <= ph_last;
      ph_valid   <= 1'b0;
      ph_last    <= 1'b0;
      underrun_r <= 1'b0;
      case (state)
        IDLE: begin
          acc <= '0;
          if (s_valid) begin
            state     <= RUN;
            sym_phase <= sym_phase_next;
            cnt       <= '0;
          end
        end
        RUN: begin
          phase    <= acc + sym_phase;
          ph_valid <= 1'b1;
          ph_last  <= last_sample;
          acc      <= acc + fcw;
          if (!last_sample) begin
            cnt <= cnt + 1'b1;
          end else if (s_valid) begin
            sym_phase <= sym_phase_next;
            cnt       <= '0;
          end else begin
            state      <= IDLE;
            underrun_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mpsk_sincos_lut #(
    .LUT_AW    (LUT_AW),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en && ph_valid),
    .addr   (LUT_AW'(phase >> ADDR_SHIFT)),
    .cos_val(m_i),
    .sin_val(m_q)
  );

endmodule

// File: tb/tb_mpsk_modulator.sv
// Directed bench for mpsk_modulator: BPSK (SPS=4) and QPSK (SPS=8) instances.
module tb_mpsk_modulator;

  typedef struct {
    int                 cyc;
    logic               last;
    logic signed [15:0] i;
    logic signed [15:0] q;
  } smp_t;

  logic clk;
  logic rstn;
  logic en;

  logic [15:0]        b_fcw;
  logic               b_s_valid, b_s_ready, b_m_valid, b_m_last, b_underrun;
  logic [0:0]         b_s_bits;
  logic signed [15:0] b_m_i, b_m_q;

  logic [15:0]        q_fcw;
  logic               q_s_valid, q_s_ready, q_m_valid, q_m_last, q_underrun;
  logic [1:0]         q_s_bits;
  logic signed [15:0] q_m_i, q_m_q;

  int   cyc = 0;
  int   q_gap_valid = 0;
  smp_t b_log[$];
  smp_t q_log[$];
  int   b_urun[$];
  int   q_urun[$];

  int total = 0;
  int bad   = 0;
  int qb, ub, a0, a1, d0, n;
  int qi_exp[4] = '{32767, 0, -32767, 0};
  int qq_exp[4] = '{0, 32767, 0, -32767};

  mpsk_modulator #(.M_BITS(1), .SPS(4), .PHASE_W(16), .LUT_AW(8), .DATA_WIDTH(16)) u_bpsk (
    .clk(clk), .rstn(rstn), .en(en), .fcw(b_fcw), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_bits(b_s_bits), .m_valid(b_m_valid), .m_last(b_m_last), .m_i(b_m_i), .m_q(b_m_q),
    .underrun(b_underrun)
  );

  mpsk_modulator #(.M_BITS(2), .SPS(8), .PHASE_W(16), .LUT_AW(8), .DATA_WIDTH(16)) u_qpsk (
    .clk(clk), .rstn(rstn), .en(en), .fcw(q_fcw), .s_valid(q_s_valid), .s_ready(q_s_ready),
    .s_bits(q_s_bits), .m_valid(q_m_valid), .m_last(q_m_last), .m_i(q_m_i), .m_q(q_m_q),
    .underrun(q_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic smp_t mk_smp(input int c, input logic l, input logic signed [15:0] i,
                                  input logic signed [15:0] q);
    smp_t s;
    s.cyc  = c;
    s.last = l;
    s.i    = i;
    s.q    = q;
    return s;
  endfunction

  always @(negedge clk) begin
    if (b_m_valid) b_log.push_back(mk_smp(cyc, b_m_last, b_m_i, b_m_q));
    if (q_m_valid) q_log.push_back(mk_smp(cyc, q_m_last, q_m_i, q_m_q));
    if (b_underrun) b_urun.push_back(cyc);
    if (q_underrun) q_urun.push_back(cyc);
    if (q_m_valid && !en) q_gap_valid <= q_gap_valid + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic bits, output int acc_cyc);
    int k = 0;
    b_s_bits  = bits;
    b_s_valid = 1'b1;
    while (!b_s_ready && k < 200) begin tick(); k++; end
    check("b_ready_wait", int'(b_s_ready), 1);
    tick();
    acc_cyc = cyc;
  endtask

  task automatic send_q(input logic [1:0] bits, output int acc_cyc);
    int k = 0;
    q_s_bits  = bits;
    q_s_valid = 1'b1;
    while (!q_s_ready && k < 200) begin tick(); k++; end
    check("q_ready_wait", int'(q_s_ready), 1);
    tick();
    acc_cyc = cyc;
  endtask

  task automatic chk_q(input string tag, input int idx, input int ei, input int eq);
    if (qb + idx < q_log.size()) begin
      check($sformatf("%s_i[%0d]", tag, idx), q_log[qb+idx].i, ei);
      check($sformatf("%s_q[%0d]", tag, idx), q_log[qb+idx].q, eq);
    end
  endtask

  initial begin
    rstn = 1'b1; en = 1'b1;
    b_fcw = '0; b_s_valid = 1'b0; b_s_bits = '0;
    q_fcw = '0; q_s_valid = 1'b0; q_s_bits = '0;
    #2 rstn = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_m_i", q_m_i, 0);
    check("rst_m_q", q_m_q, 0);
    check("rst_m_valid", int'(q_m_valid), 0);
    check("rst_m_last", int'(q_m_last), 0);
    check("rst_underrun", int'(q_underrun), 0);
    check("rst_s_ready_q", int'(q_s_ready), 0);
    check("rst_s_ready_b", int'(b_s_ready), 0);
    rstn = 1'b1; #1;
    check("idle_s_ready_q", int'(q_s_ready), 1);
    check("idle_s_ready_b", int'(b_s_ready), 1);
    en = 1'b0; #1;
    check("en_low_s_ready", int'(q_s_ready), 0);
    en = 1'b1; #1;

    // BPSK, fcw=0: bit 0 then bit 1 back-to-back
    send_b(1'b0, a0);
    send_b(1'b1, a1);
    b_s_valid = 1'b0;
    repeat (10) tick();
    check("bpsk_count", b_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < b_log.size()) begin
        check($sformatf("bpsk_i[%0d]", k), b_log[k].i, (k < 4) ? 32767 : -32767);
        check($sformatf("bpsk_q[%0d]", k), b_log[k].q, 0);
        check($sformatf("bpsk_last[%0d]", k), int'(b_log[k].last), int'(k % 4 == 3));
      end
    end
    check("bpsk_urun_n", b_urun.size(), 1);
    if (b_log.size() == 8) begin
      check("bpsk_latency", b_log[0].cyc, a0 + 2);
      check("bpsk_contig", b_log[7].cyc - b_log[0].cyc, 7);
      if (b_urun.size() >= 1) check("bpsk_urun_cyc", b_urun[0], b_log[7].cyc - 1);
    end

    // QPSK, fcw=0: Gray symbols 00, 01, 11, 10
    qb = q_log.size(); ub = q_urun.size();
    send_q(2'b00, a0);
    send_q(2'b01, a1);
    send_q(2'b11, a1);
    send_q(2'b10, a1);
    q_s_valid = 1'b0;
    repeat (14) tick();
    check("qpsk_count", q_log.size() - qb, 32);
    for (int k = 0; k < 32; k++) begin
      chk_q("qpsk", k, qi_exp[k/8], qq_exp[k/8]);
      if (qb + k < q_log.size())
        check($sformatf("qpsk_last[%0d]", k), int'(q_log[qb+k].last), int'(k % 8 == 7));
    end
    check("qpsk_urun_n", q_urun.size() - ub, 1);
    if (q_log.size() - qb == 32) begin
      check("qpsk_latency", q_log[qb].cyc, a0 + 2);
      check("qpsk_contig", q_log[qb+31].cyc - q_log[qb].cyc, 31);
    end

    // QPSK, fcw=0x0400: two symbols 00, then a starved end and a late symbol
    qb = q_log.size(); ub = q_urun.size();
    q_fcw = 16'h0400;
    send_q(2'b00, a0);
    send_q(2'b00, a1);
    q_s_valid = 1'b0;
    n = 0;
    while (q_urun.size() == ub && n < 100) begin tick(); n++; end
    check("fcw_urun_seen", q_urun.size() - ub, 1);
    repeat (3) tick();
    send_q(2'b00, d0);
    q_s_valid = 1'b0;
    repeat (14) tick();
    check("fcw_count", q_log.size() - qb, 24);
    chk_q("fcw", 0, 32767, 0);
    chk_q("fcw", 4, 30273, 12539);
    chk_q("fcw", 8, 23170, 23170);
    chk_q("fcw", 12, 12539, 30273);
    chk_q("fcw", 15, 3212, 32609);
    chk_q("restart", 16, 32767, 0);
    chk_q("restart", 17, 32609, 3212);
    check("fcw_urun_n", q_urun.size() - ub, 2);
    if (q_log.size() - qb == 24) begin
      for (int k = 1; k < 16; k++)
        check($sformatf("fcw_q_rise[%0d]", k), int'(q_log[qb+k].q > q_log[qb+k-1].q), 1);
      check("fcw_last7", int'(q_log[qb+7].last), 1);
      check("fcw_last8", int'(q_log[qb+8].last), 0);
      check("fcw_last15", int'(q_log[qb+15].last), 1);
      check("fcw_contig", q_log[qb+15].cyc - q_log[qb].cyc, 15);
      check("restart_gap", int'(q_log[qb+16].cyc - q_log[qb+15].cyc > 1), 1);
      check("restart_latency", q_log[qb+16].cyc, d0 + 2);
    end

    // Enable dropped for 5 cycles mid-symbol
    qb = q_log.size(); ub = q_urun.size(); a1 = q_gap_valid;
    send_q(2'b00, a0);
    q_s_valid = 1'b0;
    n = 0;
    while (q_log.size() - qb < 4 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (14) tick();
    check("en_gap_valid", q_gap_valid - a1, 0);
    check("en_count", q_log.size() - qb, 8);
    chk_q("en", 0, 32767, 0);
    chk_q("en", 4, 30273, 12539);
    chk_q("en", 7, 25329, 20787);
    check("en_urun_n", q_urun.size() - ub, 1);
    if (q_log.size() - qb == 8) begin
      for (int k = 1; k < 8; k++)
        check($sformatf("en_q_rise[%0d]", k), int'(q_log[qb+k].q > q_log[qb+k-1].q), 1);
      check("en_last7", int'(q_log[qb+7].last), 1);
      check("en_span", q_log[qb+7].cyc - q_log[qb].cyc, 12);
    end

    // Reset asserted while sample 3 of a symbol is on the outputs
    q_fcw = '0;
    qb = q_log.size();
    send_q(2'b01, a0);
    q_s_valid = 1'b0;
    n = 0;
    while (q_log.size() - qb < 3 && n < 100) begin @(negedge clk); n++; end
    #1;
    check("pre_rst_q", q_m_q, 32767);
    rstn = 1'b0; #1;
    check("mid_rst_m_i", q_m_i, 0);
    check("mid_rst_m_q", q_m_q, 0);
    check("mid_rst_m_valid", int'(q_m_valid), 0);
    check("mid_rst_m_last", int'(q_m_last), 0);
    check("mid_rst_underrun", int'(q_underrun), 0);
    check("mid_rst_s_ready", int'(q_s_ready), 0);
    tick(); tick();
    rstn = 1'b1; #1;
    check("post_rst_s_ready", int'(q_s_ready), 1);
    check("post_rst_m_valid", int'(q_m_valid), 0);
    qb = q_log.size();
    send_q(2'b11, a0);
    q_s_valid = 1'b0;
    repeat (14) tick();
    check("post_rst_count", q_log.size() - qb, 8);
    for (int k = 0; k < 8; k++) chk_q("post_rst", k, -32767, 0);
    if (q_log.size() - qb == 8) begin
      check("post_rst_latency", q_log[qb].cyc, a0 + 2);
      check("post_rst_last7", int'(q_log[qb+7].last), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
